// File: rtl/keypad_controller_pkg.sv
// ============================================================================
// Module  : keypad_controller_pkg
// Purpose : Shared types and helpers for the keypad controller: debounce FSM
//           state encoding, the empty-keyboard word and the key-index to
//           ASCII map.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } kp_state_e;

  // Keyboard word presented to the CPU when no key event is queued.
  localparam logic [15:0] KBD_NONE = 16'h0000;

  // 0-9 map to '0'-'9', 10-15 map to 'A'-'F' (8'h37 + 10 = 8'h41).
  function automatic logic [7:0] key_to_ascii(input logic [3:0] index);
    if (index < 4'd10) begin
      return 8'h30 + {4'h0, index};
    end
    return 8'h37 + {4'h0, index};
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_controller_fifo.sv
// ============================================================================
// Module  : keypad_controller_fifo
// Purpose : Generic synchronous FIFO with first-word fall-through head output.
//           A pop on an empty FIFO is ignored; a push on a full FIFO is taken
//           only when a pop frees a slot in the same cycle.
// Ports   : clk_i, reset_i           clock, synchronous active-high reset
//           push_i, push_data_i      write strobe and data
//           pop_i                    read strobe
//           head_o                   oldest entry (valid when !empty_o)
//           full_o, empty_o          occupancy flags
//           count_o                  number of stored entries
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_controller_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign w_do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the same cycle frees the head slot.
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage needs no reset: entries are only observed through count_q.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypad_controller.sv
// ============================================================================
// Module  : keypad_controller
// Purpose : Turns the raw key_index/key_valid level from the keypad scanner
//           into debounced, one-per-press ASCII events queued in a FIFO that
//           the CPU reads as a 16-bit keyboard word (0 = no key).
// Ports   : clk_i, reset_i       clock, synchronous active-high reset
//           key_index_i [3:0]    scanner key index, meaningful while valid
//           key_valid_i          scanner "key detected" level
//           rd_en_i              CPU pop strobe
//           rd_data_o [15:0]     ASCII of FIFO head, 0 when empty
//           fifo_count_o         queued event count
//           key_down_o           debounced key currently held
//           overflow_o           sticky event-dropped flag
//           clr_overflow_i       clears overflow_o (a same-cycle drop wins)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_controller
  import keypad_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,  // must be >= 2
  parameter int FIFO_DEPTH      = 4        // power of two, >= 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [3:0]                    key_index_i,
  input  logic                          key_valid_i,
  input  logic                          rd_en_i,
  output logic [15:0]                   rd_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          key_down_o,
  output logic                          overflow_o,
  input  logic                          clr_overflow_i
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  kp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             push_q, push_d;
  logic [7:0]       push_data_q, push_data_d;
  logic             overflow_q, overflow_d;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_match;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic [7:0]       w_head;

  assign w_match   = key_valid_i && (key_index_i == cand_q);
  assign w_cnt_inc = cnt_q + CNT_W'(1);
  // The FIFO only refuses a push when full and not popped this cycle.
  assign w_drop    = push_q & w_full & ~rd_en_i;

  // Confirmation is decided when the incremented count reaches the last
  // value, so the IDLE sample plus the PRESS_DB samples add up to exactly
  // DEBOUNCE_CYCLES stable samples. The event itself is staged in push_q
  // and lands in the FIFO one edge later.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    push_d      = 1'b0;
    push_data_d = key_to_ascii(cand_q);
    overflow_d  = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (key_valid_i) begin
          cand_d  = key_index_i;
          cnt_d   = '0;
          state_d = ST_PRESS_DB;
        end
      end
      ST_PRESS_DB: begin
        if (!w_match) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (w_cnt_inc == CNT_LAST) begin
          cnt_d   = '0;
          push_d  = 1'b1;
          state_d = ST_HELD;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      ST_HELD: begin
        if (!w_match) begin
          cnt_d   = '0;
          state_d = ST_REL_DB;
        end
      end
      ST_REL_DB: begin
        if (w_match) begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end else if (w_cnt_inc == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
    end
  end

  keypad_controller_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push_q),
    .push_data_i (push_data_q),
    .pop_i       (rd_en_i),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (fifo_count_o)
  );

  assign rd_data_o  = w_empty ? KBD_NONE : {8'h00, w_head};
  assign key_down_o = (state_q == ST_HELD) || (state_q == ST_REL_DB);
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_controller.sv
// ============================================================================
// Module  : tb_keypad_controller
// Purpose : Self-checking bench for keypad_controller with DEBOUNCE_CYCLES=8,
//           FIFO_DEPTH=4. A sample-history model (runs of identical samples,
//           a queue for the FIFO) is checked against the DUT every cycle;
//           directed scenarios add literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_controller;

  localparam int DEB   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ki = 4'd0;
  logic        kv = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] rd_data;
  logic [2:0]  fifo_count;
  logic        key_down;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .key_index_i    (ki),
    .key_valid_i    (kv),
    .rd_en_i        (rd_en),
    .rd_data_o      (rd_data),
    .fifo_count_o   (fifo_count),
    .key_down_o     (key_down),
    .overflow_o     (overflow),
    .clr_overflow_i (clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ascii(input int idx);
    return (idx < 10) ? 8'(48 + idx) : 8'(65 + idx - 10);
  endfunction

  // ---------------- behavioural model ----------------
  // Press: DEB consecutive samples of one key (starting from an idle sample)
  // confirm it; a differing sample abandons the attempt and is not reused.
  // Release: DEB consecutive non-matching samples end the hold.
  logic [7:0] mq[$];
  bit         m_down = 0;
  bit         m_ovf = 0;
  int         m_run = 0;
  int         m_gap = 0;
  int         m_cand = 0;
  bit         m_pend = 0;
  logic [7:0] m_pend_val = 8'h00;

  task automatic model_step();
    bit drop;
    bit same;
    if (reset) begin
      mq.delete();
      m_down = 0; m_ovf = 0; m_run = 0; m_gap = 0; m_pend = 0;
      return;
    end
    drop = 0;
    if (rd_en && mq.size() > 0) void'(mq.pop_front());
    if (m_pend) begin
      if (mq.size() < DEPTH) mq.push_back(m_pend_val);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_pend = 0;
    same = kv && (int'(ki) == m_cand);
    if (!m_down) begin
      if (m_run == 0) begin
        if (kv) begin m_cand = int'(ki); m_run = 1; end
      end else if (same) m_run++;
      else m_run = 0;
      if (m_run == DEB) begin
        m_down = 1; m_run = 0; m_gap = 0;
        m_pend = 1; m_pend_val = ascii(m_cand);
      end
    end else begin
      if (same) m_gap = 0;
      else m_gap++;
      if (m_gap == DEB) begin m_down = 0; m_gap = 0; end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("rd_data",    32'(rd_data),    (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("key_down",   32'(key_down),   32'(m_down));
    chk("overflow",   32'(overflow),   32'(m_ovf));
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic hold(input logic [3:0] k, input int n);
    kv = 1'b1; ki = k;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    kv = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop1();
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    hold(k, 10); idle(10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    repeat (3) @(negedge clk);
    chk("reset rd_data", 32'(rd_data), 32'h0);
    chk("reset count", 32'(fifo_count), 32'h0);
    chk("reset key_down", 32'(key_down), 32'h0);
    chk("reset overflow", 32'(overflow), 32'h0);
    reset = 1'b0;
    idle(2);

    // 1: clean press of key 5
    kv = 1'b1; ki = 4'd5;
    repeat (7) @(negedge clk);
    chk("t1 key_down c7", 32'(key_down), 32'h0);
    @(negedge clk);
    chk("t1 key_down c8", 32'(key_down), 32'h1);
    chk("t1 rd_data c8", 32'(rd_data), 32'h0);
    @(negedge clk);
    chk("t1 rd_data c9", 32'(rd_data), 32'h0035);
    chk("t1 count", 32'(fifo_count), 32'h1);
    repeat (11) @(negedge clk);
    idle(20);
    chk("t1 released", 32'(key_down), 32'h0);
    pop1();

    // 2: bouncing key 14
    hold(4'd14, 3); idle(1); hold(4'd14, 3); idle(15);
    chk("t2 count", 32'(fifo_count), 32'h0);
    chk("t2 rd_data", 32'(rd_data), 32'h0);

    // 3: brief gap inside a hold
    hold(4'd3, 12); idle(4); hold(4'd3, 5); idle(10);
    chk("t3 count", 32'(fifo_count), 32'h1);
    chk("t3 rd_data", 32'(rd_data), 32'h0033);
    pop1();

    // 4: overflow
    for (int k = 1; k <= 5; k++) press(4'(k));
    chk("t4 count", 32'(fifo_count), 32'h4);
    chk("t4 overflow", 32'(overflow), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      chk("t4 pop data", 32'(rd_data), 32'(ascii(k)));
      pop1();
    end
    chk("t4 empty rd", 32'(rd_data), 32'h0);
    pop1();
    chk("t4 pop empty", 32'(fifo_count), 32'h0);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("t4 clr", 32'(overflow), 32'h0);

    // 5: push and pop together while full
    for (int k = 1; k <= 4; k++) press(4'(k));
    chk("t5 full", 32'(fifo_count), 32'h4);
    kv = 1'b1; ki = 4'd9;
    repeat (8) @(negedge clk);
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    chk("t5 count", 32'(fifo_count), 32'h4);
    chk("t5 overflow", 32'(overflow), 32'h0);
    hold(4'd9, 2); idle(10);
    for (int k = 2; k <= 5; k++) begin
      chk("t5 pop data", 32'(rd_data), (k == 5) ? 32'h0039 : 32'(ascii(k)));
      pop1();
    end

    // 6: reset mid-debounce with one event queued
    press(4'd7);
    chk("t6 queued", 32'(fifo_count), 32'h1);
    hold(4'd10, 4);
    reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
    chk("t6 rd after rst", 32'(rd_data), 32'h0);
    chk("t6 count after rst", 32'(fifo_count), 32'h0);
    chk("t6 kd after rst", 32'(key_down), 32'h0);
    repeat (8) @(negedge clk);
    chk("t6 rd c8", 32'(rd_data), 32'h0);
    @(negedge clk);
    chk("t6 rd c9", 32'(rd_data), 32'h0041);
    idle(10);
    pop1();

    // random phase
    for (int s = 0; s < 250; s++) begin
      kv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ki = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 14);
      repeat (len) begin
        rd_en = ($urandom_range(0, 5) == 0);
        clr   = ($urandom_range(0, 15) == 0);
        reset = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
    end
    rd_en = 1'b0; clr = 1'b0; reset = 1'b0; kv = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
